// File: rtl/mac_fifo_pkg.sv
// Shared types for the MAC FIFO loader: FSM state encoding, word geometry and lane byte type.
package mac_fifo_pkg;

  localparam int WORD_BYTES = 8;

  typedef logic [7:0] lane_byte_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILLCHK,
    S_RUN,
    S_DONE
  } loader_state_e;

endpackage

// File: rtl/mac_fifo_loader.sv
// Loads DATA_WIDTH 64-bit words from memory, scatters bytes across per-lane FIFOs, then runs the MAC array.
// Define LOADER_PERF_CNT_EN to add the perf_cycles start-to-done cycle counter.
module mac_fifo_loader
  import mac_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_read,
  input  logic                    mem_waitrequest,
  input  logic [63:0]             mem_readdata,
  input  logic                    mem_readdatavalid,
  output logic [DATA_WIDTH*8-1:0] fifo_wrdata,
  output logic [DATA_WIDTH-1:0]   fifo_wren,
  input  logic [DATA_WIDTH-1:0]   fifo_full,
  input  logic [DATA_WIDTH-1:0]   fifo_empty,
  output logic                    mac_en,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef LOADER_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ALL  = CNT_W'(DATA_WIDTH);

  loader_state_e     st, nxt;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  issue_cnt, ret_cnt, fill_cnt;
  logic              accept, ret_vld, drop, start_ok;

  assign start_ok = (st == S_IDLE) && start;
  assign accept   = (st == S_REQ) && !mem_waitrequest;
  // Returns only count while a load is collecting data; stragglers elsewhere are dropped silently.
  assign ret_vld  = mem_readdatavalid && ((st == S_REQ) || (st == S_WAIT));
  assign drop     = ret_vld && (|fifo_full);
  assign busy     = (st != S_IDLE);

  assign fifo_wren = {DATA_WIDTH{ret_vld && !(|fifo_full)}};

  // Little-endian scatter; lanes past the word width wrap onto its bytes.
  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_lane
    assign fifo_wrdata[8*k +: 8] = lane_byte_t'(mem_readdata[8*(k % WORD_BYTES) +: 8]);
  end

  always_comb begin
    nxt      = st;
    mem_read = 1'b0;
    mem_addr = '0;
    mac_en   = 1'b0;
    done     = 1'b0;
    case (st)
      S_IDLE:    if (start) nxt = S_REQ;
      S_REQ: begin
        mem_read = 1'b1;
        mem_addr = base_q + ADDR_W'(WORD_BYTES) * ADDR_W'(issue_cnt);
        if (accept && (issue_cnt == CNT_LAST)) nxt = S_WAIT;
      end
      S_WAIT:    if (ret_cnt == CNT_ALL) nxt = S_FILLCHK;
      S_FILLCHK: if ((&fifo_full) || (fill_cnt == CNT_LAST)) nxt = S_RUN;
      S_RUN: begin
        mac_en = 1'b1;
        if (&fifo_empty) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      base_q    <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      fill_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      st       <= nxt;
      fill_cnt <= (st == S_FILLCHK) ? fill_cnt + 1'b1 : '0;
      if (start_ok) begin
        base_q    <= base_addr;
        issue_cnt <= '0;
        ret_cnt   <= '0;
        err       <= 1'b0;
      end else begin
        if (accept)  issue_cnt <= issue_cnt + 1'b1;
        if (ret_vld) ret_cnt   <= ret_cnt + 1'b1;
        if (drop)    err       <= 1'b1;
      end
    end
  end

`ifdef LOADER_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        perf_q <= '0;
    else if (start_ok) perf_q <= '0;
    else if (busy)     perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
